id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter: XLEN, 32, datapath width in bits.
REQ-002 Parameter: NREG, 32, number of architectural registers (power of 2, 8..64).
REQ-003 Parameter: RAW, $clog2(NREG), register-address width.
REQ-004 Port: IFtoID_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 Port: IFtoID_rst  in  1  reset, synchronous and active-high.
REQ-006 Port: IFtoID_valid  in  1  IF/ID holds a real instruction.
REQ-007 Port: IFtoID_PC  in  XLEN  PC of the instruction in IF/ID.
REQ-008 Port: IFtoID_inst  in  32  instruction word.
REQ-009 Port: WB_RegWrite  in  1  write-back enable.
REQ-010 Port: WB_WR  in  RAW  write-back destination register.
REQ-011 Port: WB_WD  in  XLEN  write-back data.
REQ-012 Port: EX_flush  in  1  taken branch; kill the instruction entering ID/EX.
REQ-013 Port: ID_stall  out  1  hold PC and IF/ID this cycle.
REQ-014 Port: IDtoEX_valid  out  1  ID/EX holds a real instruction.
REQ-015 Port: IDtoEX_PC, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm  out  XLEN each  registered PC, operands, sign-extended immediate.
REQ-016 Port: IDtoEX_Rs, IDtoEX_Rt, IDtoEX_Rd  out  RAW each  registered inst[25:21], [20:16], [15:11], zero-extended or truncated to RAW.
REQ-017 Port: IDtoEX_ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg  out  1 each; IDtoEX_ALUOp  out  2  registered control.

Function
REQ-018 Decode SHALL be: R-type 000000 -> RegDst,RegWrite,ALUOp=10; lw 100011 -> ALUSrc,MemRead,RegWrite,MemtoReg,ALUOp=00; sw 101011 -> ALUSrc,MemWrite,ALUOp=00; beq 000100 -> Branch,ALUOp=01; addi 001000 -> ALUSrc,RegWrite,ALUOp=00; any other opcode -> all controls 0.
REQ-019 Imm SHALL be inst[15:0] sign-extended to XLEN.
REQ-020 Register file: NREG x XLEN; register 0 reads 0 and ignores writes; write at clock edge when WB_RegWrite=1 and WB_WR!=0.
REQ-021 Reads SHALL be combinational with write-through bypass: if WB_RegWrite=1, WB_WR!=0 and WB_WR equals the read address, read data is WB_WD in that same cycle.
REQ-022 Load-use hazard SHALL be: IFtoID_valid & IDtoEX_valid & IDtoEX_MemRead & IDtoEX_Rt!=0 & (IDtoEX_Rt==Rs | (IDtoEX_Rt==Rt & opcode is R-type, sw or beq)).
REQ-023 ID_stall SHALL equal hazard & !EX_flush, combinationally.
REQ-024 ID/EX update priority per edge: reset > EX_flush (bubble) > hazard (bubble) > load decoded instruction.
REQ-025 Bubble SHALL be IDtoEX_valid=0 with all control outputs 0; data fields may retain prior values.
REQ-026 Load SHALL set IDtoEX_valid=IFtoID_valid; when IFtoID_valid=0 all loaded controls are 0.
REQ-027 Latency IF/ID to ID/EX SHALL be exactly one cycle; one stall cycle per load-use pair, never more.
REQ-028 Simultaneous WB write and ID read of the same register in a stall cycle SHALL deliver new data on the following (non-stall) load.

Reset
REQ-029 While IFtoID_rst=1 at an edge, all ID/EX outputs and all NREG registers SHALL become 0; ID_stall SHALL be 0 in the cycle after.
REQ-030 Reset asserted mid-stall SHALL discard the stalled instruction; no write-back occurs during a reset edge.

Structure
REQ-031 A shared package SHALL hold opcode constants, ALUOp encodings (00 add, 01 sub, 10 funct) and default parameter values.
REQ-032 The register file SHALL be one sub-module, id_regfile, parametrised by XLEN and NREG, containing the bypass.

Verification
REQ-033 Reset, then addi r1,r0,5 (0x20010005) -> next cycle IDtoEX_valid=1, Imm=5, ALUSrc=1, RegWrite=1, ALUOp=00.
REQ-034 WB writes r3=0xDEADBEEF same cycle ID reads add r4,r3,r3 -> ReadData1=ReadData2=0xDEADBEEF on next edge.
REQ-035 lw r2,0(r1) followed by add r5,r2,r6 -> ID_stall=1 one cycle, one bubble (valid=0), add loads next cycle.
REQ-036 lw r2 followed by addi r2,r2,1 (Rt not a source) -> Rs match still stalls; lw r2 then addi r7,r8,1 -> no stall.
REQ-037 EX_flush=1 concurrent with load-use hazard -> ID_stall=0, ID/EX gets bubble.
REQ-038 NREG=8, XLEN=16 build: write r0 with 0x1234 -> r0 reads 0; Imm of 0x8000 reads 0x8000 (16-bit sign-extended).

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the ID stage: default parameter values, opcode
// constants, ALUOp encodings, the control bundle and the main decoder.
package id_stage_pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   alu_src;
    logic   reg_dst;
    logic   branch;
    logic   mem_read;
    logic   mem_write;
    logic   reg_write;
    logic   mem_to_reg;
    aluop_e alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Opcodes that actually consume the Rt field as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// id_regfile: NREG x XLEN register file, register 0 hardwired to zero.
// Ports: clk/rst (sync, active-high), we/wa/wd write port,
//        ra1/ra2 read addresses, rd1/rd2 combinational read data with
//        write-through bypass from the write port.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd,
  input  logic [RAW-1:0]  ra1,
  input  logic [RAW-1:0]  ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Bypass never hits r0 because wr_en excludes address 0.
  assign rd1 = (wr_en && (wa == ra1)) ? wd : mem_q[ra1];
  assign rd2 = (wr_en && (wa == ra2)) ? wd : mem_q[ra2];

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage and ID/EX pipeline register.
// Inputs: IF/ID instruction (valid, PC, inst), write-back port, EX_flush.
// Outputs: ID_stall (combinational load-use stall), registered ID/EX
//          fields: valid, PC, operands, immediate, Rs/Rt/Rd and controls.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int RAW  = $clog2(NREG)
) (
  input  logic            IFtoID_clk,
  input  logic            IFtoID_rst,
  input  logic            IFtoID_valid,
  input  logic [XLEN-1:0] IFtoID_PC,
  input  logic [31:0]     IFtoID_inst,
  input  logic            WB_RegWrite,
  input  logic [RAW-1:0]  WB_WR,
  input  logic [XLEN-1:0] WB_WD,
  input  logic            EX_flush,
  output logic            ID_stall,
  output logic            IDtoEX_valid,
  output logic [XLEN-1:0] IDtoEX_PC,
  output logic [XLEN-1:0] IDtoEX_ReadData1,
  output logic [XLEN-1:0] IDtoEX_ReadData2,
  output logic [XLEN-1:0] IDtoEX_Imm,
  output logic [RAW-1:0]  IDtoEX_Rs,
  output logic [RAW-1:0]  IDtoEX_Rt,
  output logic [RAW-1:0]  IDtoEX_Rd,
  output logic            IDtoEX_ALUSrc,
  output logic            IDtoEX_RegDst,
  output logic            IDtoEX_Branch,
  output logic            IDtoEX_MemRead,
  output logic            IDtoEX_MemWrite,
  output logic            IDtoEX_RegWrite,
  output logic            IDtoEX_MemtoReg,
  output logic [1:0]      IDtoEX_ALUOp
);

  logic [5:0]      opcode;
  logic [RAW-1:0]  rs, rt, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic            hazard;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RAW-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;

  assign opcode = IFtoID_inst[31:26];
  assign rs     = RAW'(IFtoID_inst[25:21]);
  assign rt     = RAW'(IFtoID_inst[20:16]);
  assign rd     = RAW'(IFtoID_inst[15:11]);
  assign imm    = XLEN'($signed(IFtoID_inst[15:0]));

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) u_regfile (
    .clk (IFtoID_clk),
    .rst (IFtoID_rst),
    .we  (WB_RegWrite),
    .wa  (WB_WR),
    .wd  (WB_WD),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rdata1),
    .rd2 (rdata2)
  );

  assign hazard = IFtoID_valid && valid_q && ctrl_q.mem_read && (rt_q != '0) &&
                  ((rt_q == rs) || ((rt_q == rt) && uses_rt(opcode)));

  assign ID_stall = hazard && !EX_flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (EX_flush || hazard) begin
      // Bubble: data fields hold, only valid and controls drop.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = IFtoID_valid;
      pc_d    = IFtoID_PC;
      rd1_d   = rdata1;
      rd2_d   = rdata2;
      imm_d   = imm;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      ctrl_d  = IFtoID_valid ? decode(opcode) : '0;
    end
  end

  always_ff @(posedge IFtoID_clk) begin
    if (IFtoID_rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign IDtoEX_valid     = valid_q;
  assign IDtoEX_PC        = pc_q;
  assign IDtoEX_ReadData1 = rd1_q;
  assign IDtoEX_ReadData2 = rd2_q;
  assign IDtoEX_Imm       = imm_q;
  assign IDtoEX_Rs        = rs_q;
  assign IDtoEX_Rt        = rt_q;
  assign IDtoEX_Rd        = rd_q;
  assign IDtoEX_ALUSrc    = ctrl_q.alu_src;
  assign IDtoEX_RegDst    = ctrl_q.reg_dst;
  assign IDtoEX_Branch    = ctrl_q.branch;
  assign IDtoEX_MemRead   = ctrl_q.mem_read;
  assign IDtoEX_MemWrite  = ctrl_q.mem_write;
  assign IDtoEX_RegWrite  = ctrl_q.reg_write;
  assign IDtoEX_MemtoReg  = ctrl_q.mem_to_reg;
  assign IDtoEX_ALUOp     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a default 32x32 instance and an
// 8-register, 16-bit instance, sharing clock and reset.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wd;
  logic        flush;

  logic        stall, o_valid, o_alusrc, o_regdst, o_branch, o_memread;
  logic        o_memwrite, o_regwrite, o_memtoreg;
  logic [1:0]  o_aluop;
  logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;

  logic        s_valid, s_we;
  logic [15:0] s_pc, s_wd;
  logic [31:0] s_inst;
  logic [2:0]  s_wr;
  logic        s_stall, s_ovalid, s_alusrc, s_regdst, s_branch, s_memread;
  logic        s_memwrite, s_regwrite, s_memtoreg;
  logic [1:0]  s_aluop;
  logic [15:0] s_opc, s_rd1, s_rd2, s_imm;
  logic [2:0]  s_rs, s_rt, s_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .IFtoID_clk(clk), .IFtoID_rst(rst), .IFtoID_valid(valid),
    .IFtoID_PC(pc), .IFtoID_inst(inst),
    .WB_RegWrite(wb_we), .WB_WR(wb_wr), .WB_WD(wb_wd), .EX_flush(flush),
    .ID_stall(stall), .IDtoEX_valid(o_valid), .IDtoEX_PC(o_pc),
    .IDtoEX_ReadData1(o_rd1), .IDtoEX_ReadData2(o_rd2), .IDtoEX_Imm(o_imm),
    .IDtoEX_Rs(o_rs), .IDtoEX_Rt(o_rt), .IDtoEX_Rd(o_rd),
    .IDtoEX_ALUSrc(o_alusrc), .IDtoEX_RegDst(o_regdst), .IDtoEX_Branch(o_branch),
    .IDtoEX_MemRead(o_memread), .IDtoEX_MemWrite(o_memwrite),
    .IDtoEX_RegWrite(o_regwrite), .IDtoEX_MemtoReg(o_memtoreg),
    .IDtoEX_ALUOp(o_aluop)
  );

  id_stage_pipe #(.XLEN(16), .NREG(8)) dut16 (
    .IFtoID_clk(clk), .IFtoID_rst(rst), .IFtoID_valid(s_valid),
    .IFtoID_PC(s_pc), .IFtoID_inst(s_inst),
    .WB_RegWrite(s_we), .WB_WR(s_wr), .WB_WD(s_wd), .EX_flush(1'b0),
    .ID_stall(s_stall), .IDtoEX_valid(s_ovalid), .IDtoEX_PC(s_opc),
    .IDtoEX_ReadData1(s_rd1), .IDtoEX_ReadData2(s_rd2), .IDtoEX_Imm(s_imm),
    .IDtoEX_Rs(s_rs), .IDtoEX_Rt(s_rt), .IDtoEX_Rd(s_rd),
    .IDtoEX_ALUSrc(s_alusrc), .IDtoEX_RegDst(s_regdst), .IDtoEX_Branch(s_branch),
    .IDtoEX_MemRead(s_memread), .IDtoEX_MemWrite(s_memwrite),
    .IDtoEX_RegWrite(s_regwrite), .IDtoEX_MemtoReg(s_memtoreg),
    .IDtoEX_ALUOp(s_aluop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All control outputs packed as {ALUSrc,RegDst,Branch,MemRead,MemWrite,RegWrite,MemtoReg,ALUOp}.
  function automatic logic [31:0] ctl();
    return {23'd0, o_alusrc, o_regdst, o_branch, o_memread, o_memwrite,
            o_regwrite, o_memtoreg, o_aluop};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; pc = 32'h0; inst = 32'h8C220000; flush = 1'b0;
    wb_we = 1'b1; wb_wr = 5'd1; wb_wd = 32'h00000055;
    s_valid = 1'b0; s_pc = 16'h0; s_inst = 32'h0; s_we = 1'b0; s_wr = 3'd0; s_wd = 16'h0;
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ctl", ctl(), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_rd1", o_rd1, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Reduced build: r0 write ignored, 16-bit sign-extension.
    rst = 1'b0; wb_we = 1'b0;
    s_valid = 1'b1; s_inst = 32'h20018000; s_we = 1'b1; s_wr = 3'd0; s_wd = 16'h1234;
    inst = 32'h20010005; pc = 32'h00000100;
    step();
    chk("n8_r0_bypass", {16'd0, s_rd1}, 32'd0);
    chk("n8_imm", {16'd0, s_imm}, 32'h00008000);
    s_we = 1'b0;
    step();
    chk("n8_r0_read", {16'd0, s_rd1}, 32'd0);
    chk("n8_rt", {29'd0, s_rt}, 32'd1);

    // addi r1,r0,5 loaded on the first edge after reset (and again just now).
    chk("addi_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_ctl", ctl(), 32'b1000010_00 << 0);
    chk("addi_pc", o_pc, 32'h00000100);
    chk("addi_r1_not_written_in_rst", o_rd2, 32'd0);

    // add r4,r3,r3 while WB writes r3.
    inst = 32'h00632020; wb_we = 1'b1; wb_wr = 5'd3; wb_wd = 32'hDEADBEEF;
    step();
    wb_we = 1'b0;
    chk("bypass_rd1", o_rd1, 32'hDEADBEEF);
    chk("bypass_rd2", o_rd2, 32'hDEADBEEF);
    chk("add_ctl", ctl(), 32'b0100010_10);
    chk("add_rd", {27'd0, o_rd}, 32'd4);
    step();
    chk("r3_stored", o_rd1, 32'hDEADBEEF);

    // lw r2,0(r1) then add r5,r2,r6 -> one stall, one bubble.
    inst = 32'h8C220000;
    #1 chk("lw_no_stall", {31'd0, stall}, 32'd0);
    step();
    chk("lw_ctl", ctl(), 32'b1001011_00);
    chk("lw_rt", {27'd0, o_rt}, 32'd2);
    inst = 32'h00462820;
    #1 chk("lu_rs_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'd0, o_valid}, 32'd0);
    chk("lu_bubble_ctl", ctl(), 32'd0);
    chk("lu_stall_once", {31'd0, stall}, 32'd0);
    step();
    chk("lu_add_valid", {31'd0, o_valid}, 32'd1);
    chk("lu_add_regs", {21'd0, o_rs, o_rt, o_rd[0]}, {21'd0, 5'd2, 5'd6, 1'b1});

    // lw r2 then addi r2,r2,1 -> Rs match stalls.
    inst = 32'h8C220000;
    step();
    inst = 32'h20420001;
    #1 chk("addi_rs_stall", {31'd0, stall}, 32'd1);
    step();
    chk("addi_rs_bubble", {31'd0, o_valid}, 32'd0);
    step();
    chk("addi_rs_load", o_imm, 32'd1);
    // lw r2 then addi r7,r8,1 -> no stall (Rt of addi is a destination).
    inst = 32'h8C220000;
    step();
    inst = 32'h21070001;
    #1 chk("addi_nomatch_stall", {31'd0, stall}, 32'd0);
    step();
    chk("addi_nomatch_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_nomatch_rt", {27'd0, o_rt}, 32'd7);

    // lw r2 then sw r2,4(r6): Rt source stall, WB writes r2 in stall cycle.
    inst = 32'h8C220000;
    step();
    inst = 32'hACC20004; wb_we = 1'b1; wb_wr = 5'd2; wb_wd = 32'hCAFEF00D;
    #1 chk("sw_rt_stall", {31'd0, stall}, 32'd1);
    step();
    wb_we = 1'b0;
    chk("sw_bubble", {31'd0, o_valid}, 32'd0);
    step();
    chk("sw_new_data", o_rd2, 32'hCAFEF00D);
    chk("sw_ctl", ctl(), 32'b1000100_00);
    chk("sw_imm", o_imm, 32'd4);

    // Flush concurrent with load-use hazard.
    inst = 32'h8C220000;
    step();
    inst = 32'h00462820; flush = 1'b1;
    #1 chk("flush_no_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_bubble_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_bubble_ctl", ctl(), 32'd0);
    step();
    chk("flush_then_add", ctl(), 32'b0100010_10);

    // beq r1,r2,-1 ; unknown opcode ; invalid slot.
    inst = 32'h1022FFFF;
    step();
    chk("beq_ctl", ctl(), 32'b0010000_01);
    chk("beq_imm", o_imm, 32'hFFFFFFFF);
    inst = 32'hFC000000;
    step();
    chk("unk_valid", {31'd0, o_valid}, 32'd1);
    chk("unk_ctl", ctl(), 32'd0);
    valid = 1'b0; inst = 32'h8C220000;
    step();
    chk("inv_valid", {31'd0, o_valid}, 32'd0);
    chk("inv_ctl", ctl(), 32'd0);

    // Reset mid-stall discards the instruction and blocks write-back.
    valid = 1'b1;
    step();
    inst = 32'h00462820;
    #1 chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; wb_we = 1'b1; wb_wr = 5'd3; wb_wd = 32'h00001234;
    step();
    rst = 1'b0; wb_we = 1'b0;
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_ctl", ctl(), 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    inst = 32'h00632020;
    step();
    chk("midrst_r3_cleared", o_rd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
